rr_arb_mux: RTL and testbench
=============================

RR_ARB_MUX -- requirements
Module: rr_arb_mux

Interface
REQ-001 Parameter WIDTH, default 8, SHALL set the data bits per channel.
REQ-002 Parameter NUM_CH, default 4, SHALL set the input channel count; NUM_CH < 2 SHALL fail elaboration.
REQ-003 Parameter CNT_W, default 16, SHALL set the transfer-counter width.
REQ-004 clk_in  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-005 rst_in  input  1  SHALL be the reset: asynchronous, active-high.
REQ-006 mode_in  input  1  SHALL select arbitration: 0 = round-robin, 1 = fixed priority (lowest index wins).
REQ-007 valid_in  input  NUM_CH  SHALL carry per-channel request/valid.
REQ-008 data_in  input  NUM_CH*WIDTH  SHALL carry channel i data in bits [i*WIDTH +: WIDTH].
REQ-009 ready_out  output  NUM_CH  SHALL carry per-channel accept.
REQ-010 valid_out  output  1  SHALL flag that the output register holds data.
REQ-011 data_out  output  WIDTH  SHALL carry the registered selected data.
REQ-012 ch_out  output  $clog2(NUM_CH)  SHALL carry the source channel index of data_out.
REQ-013 ready_in  input  1  SHALL carry downstream accept.
REQ-014 xfer_cnt_out  output  CNT_W  SHALL carry the count of completed output handshakes.

Function
REQ-015 Internal load SHALL equal (!valid_out | ready_in), combinationally.
REQ-016 Grant SHALL be one-hot among asserted valid_in bits, or all-zero when none is asserted.
REQ-017 ready_out[i] SHALL equal load & grant[i]; at most one bit SHALL be high per cycle.
REQ-018 An input transfer on channel i SHALL occur when valid_in[i] & ready_out[i].
REQ-019 On an input transfer, data_out/ch_out SHALL take the granted data/index and valid_out SHALL be 1 the next cycle (latency 1).
REQ-020 When load = 1 and no valid_in is asserted, valid_out SHALL go to 0 the next cycle.
REQ-021 While valid_out & !ready_in, data_out and ch_out SHALL hold stable and ready_out SHALL be all-zero.
REQ-022 Simultaneous output handshake and input transfer SHALL replace the register contents in the same edge (no bubble); sustained ready_in = 1 SHALL sustain one transfer per cycle.
REQ-023 Round-robin: the search SHALL start at pointer ptr and proceed upward, wrapping NUM_CH-1 -> 0; the first valid channel wins.
REQ-024 ptr SHALL update to (granted index + 1) mod NUM_CH only on an input transfer, in either mode.
REQ-025 Fixed priority SHALL ignore ptr for selection.
REQ-026 A mode_in change SHALL affect the grant in the same cycle; ptr SHALL be retained across mode changes.
REQ-027 xfer_cnt_out SHALL increment on each valid_out & ready_in and SHALL wrap from 2^CNT_W-1 to 0.
REQ-028 valid_in deasserted before grant SHALL be permitted and SHALL NOT be an error.

Reset
REQ-029 On rst_in = 1, valid_out SHALL be 0, data_out 0, ch_out 0, ptr 0, and xfer_cnt_out 0, immediately and independent of clk_in.
REQ-030 While rst_in = 1, ready_out SHALL be all-zero.
REQ-031 Reset asserted mid-stream SHALL discard held data; the first grant after release SHALL use ptr = 0.

Structure
REQ-032 Shared package mux_pkg SHALL hold MODE_RR = 1'b0 and MODE_FIXED = 1'b1.
REQ-033 The grant logic (valid vector, ptr, mode -> one-hot grant + index) SHALL be a sub-module rr_arbiter; the output register, ptr, and counter SHALL live in rr_arb_mux.

Verification (WIDTH=8, NUM_CH=4)
REQ-034 RR fairness: valid_in=4'b1111, data i = 8'hA0+i, ready_in=1, mode 0 -> ch_out sequence 0,1,2,3,0 on consecutive cycles; xfer_cnt_out increments by 1 per cycle.
REQ-035 Fixed priority: valid_in=4'b1010, mode 1 -> ch_out stays 1 each cycle; ready_out[3] stays 0.
REQ-036 Backpressure: output holds ch 2 data 8'h5C, ready_in=0 for 3 cycles -> data_out/ch_out stable, ready_out=0; on ready_in=1 the next grant loads the following cycle.
REQ-037 Wrap: ptr=3, valid_in=4'b0011 -> ch 0 granted, ptr becomes 1; CNT_W=4 with 16 handshakes -> xfer_cnt_out returns to 0.
REQ-038 Reset mid-operation: rst_in pulsed while valid_out=1 -> valid_out=0 within the same cycle; after release, valid_in=4'b1111 grants ch 0.
REQ-039 Mode switch: RR ptr=2, switch to mode 1 with valid_in=4'b1100 -> grant ch 2; switch back to mode 0 -> ptr is 3 and ch 3 is granted next.

Source files
------------

// File: rtl/mux_pkg.sv
// Shared constants and helpers for the round-robin arbitrating mux.
// Mode encodings are used by both the arbiter and the top-level register stage.
package mux_pkg;

    localparam logic MODE_RR    = 1'b0;
    localparam logic MODE_FIXED = 1'b1;

    // Next pointer value after a grant, wrapping at the channel count.
    function automatic int wrap_inc(input int idx, input int n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational grant logic: round-robin search from a pointer, or fixed
// priority with the lowest index winning. Produces a one-hot grant plus index.
module rr_arbiter
    import mux_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int IDX_W  = $clog2(NUM_CH)
) (
    input  logic [NUM_CH-1:0] valid_in,
    input  logic [IDX_W-1:0]  ptr_in,
    input  logic              mode_in,
    output logic [NUM_CH-1:0] grant_out,
    output logic [IDX_W-1:0]  grant_idx_out,
    output logic              grant_vld_out
);

    int   base;
    int   cand;
    logic found;

    // Walk the channels starting at the base; the first requester wins.
    always_comb begin
        grant_out     = '0;
        grant_idx_out = '0;
        found         = 1'b0;
        cand          = 0;
        base          = (mode_in == MODE_FIXED) ? 0 : int'(ptr_in);
        for (int k = 0; k < NUM_CH; k++) begin
            cand = base + k;
            if (cand >= NUM_CH) begin
                cand = cand - NUM_CH;
            end
            if (!found && valid_in[cand]) begin
                found            = 1'b1;
                grant_out[cand]  = 1'b1;
                grant_idx_out    = IDX_W'(cand);
            end
        end
        grant_vld_out = found;
    end

endmodule

// File: rtl/rr_arb_mux.sv
// N-to-1 arbitrating mux with a single registered output stage, valid/ready
// handshakes on both sides, and a count of completed output transfers.
module rr_arb_mux
    import mux_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int NUM_CH = 4,
    parameter int CNT_W  = 16
) (
    input  logic                       clk_in,
    input  logic                       rst_in,
    input  logic                       mode_in,
    input  logic [NUM_CH-1:0]          valid_in,
    input  logic [NUM_CH*WIDTH-1:0]    data_in,
    output logic [NUM_CH-1:0]          ready_out,
    output logic                       valid_out,
    output logic [WIDTH-1:0]           data_out,
    output logic [$clog2(NUM_CH)-1:0]  ch_out,
    input  logic                       ready_in,
    output logic [CNT_W-1:0]           xfer_cnt_out
);

    localparam int IDX_W = $clog2(NUM_CH);

    generate
        if (NUM_CH < 2) begin : g_bad_num_ch
            $error("rr_arb_mux: NUM_CH must be at least 2");
        end
    endgenerate

    logic              valid_q, valid_d;
    logic [WIDTH-1:0]  data_q,  data_d;
    logic [IDX_W-1:0]  ch_q,    ch_d;
    logic [IDX_W-1:0]  ptr_q,   ptr_d;
    logic [CNT_W-1:0]  cnt_q,   cnt_d;

    logic [NUM_CH-1:0] grant;
    logic [IDX_W-1:0]  grant_idx;
    logic              grant_vld;
    logic              load;
    logic [WIDTH-1:0]  sel_data;

    rr_arbiter #(
        .NUM_CH (NUM_CH),
        .IDX_W  (IDX_W)
    ) u_arbiter (
        .valid_in      (valid_in),
        .ptr_in        (ptr_q),
        .mode_in       (mode_in),
        .grant_out     (grant),
        .grant_idx_out (grant_idx),
        .grant_vld_out (grant_vld)
    );

    // The register may accept new data when empty or being drained this cycle.
    always_comb begin
        load      = !valid_q || ready_in;
        ready_out = (load && !rst_in) ? grant : '0;
        sel_data  = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (grant[i]) begin
                sel_data = data_in[i*WIDTH +: WIDTH];
            end
        end
    end

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        ch_d    = ch_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        if (valid_q && ready_in) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
        if (load) begin
            valid_d = grant_vld;
            if (grant_vld) begin
                data_d = sel_data;
                ch_d   = grant_idx;
                ptr_d  = IDX_W'(wrap_inc(int'(grant_idx), NUM_CH));
            end
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            ch_q    <= '0;
            ptr_q   <= '0;
            cnt_q   <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            ch_q    <= ch_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
        end
    end

    assign valid_out    = valid_q;
    assign data_out     = data_q;
    assign ch_out       = ch_q;
    assign xfer_cnt_out = cnt_q;

endmodule

// File: tb/tb_rr_arb_mux.sv
// Bench for rr_arb_mux: a cycle-level reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_rr_arb_mux;

    localparam int W  = 8;
    localparam int N  = 4;
    localparam int CW = 4;

    logic             clk_in   = 1'b0;
    logic             rst_in   = 1'b1;
    logic             mode_in  = 1'b0;
    logic             ready_in = 1'b0;
    logic [N-1:0]     valid_in = '0;
    logic [N*W-1:0]   data_in  = '0;
    logic [N-1:0]     ready_out;
    logic             valid_out;
    logic [W-1:0]     data_out;
    logic [1:0]       ch_out;
    logic [CW-1:0]    xfer_cnt_out;

    int checks = 0;
    int errors = 0;

    rr_arb_mux #(
        .WIDTH  (W),
        .NUM_CH (N),
        .CNT_W  (CW)
    ) dut (
        .clk_in       (clk_in),
        .rst_in       (rst_in),
        .mode_in      (mode_in),
        .valid_in     (valid_in),
        .data_in      (data_in),
        .ready_out    (ready_out),
        .valid_out    (valid_out),
        .data_out     (data_out),
        .ch_out       (ch_out),
        .ready_in     (ready_in),
        .xfer_cnt_out (xfer_cnt_out)
    );

    always #5 clk_in = ~clk_in;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual %0h required %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: registered state as the spec describes it.
    logic         m_valid;
    logic [W-1:0] m_data;
    int           m_ch, m_ptr, m_cnt;
    int           g, start, c;
    logic         m_load;
    logic [N-1:0] exp_rdy;

    always begin : model
        @(negedge clk_in);
        if (rst_in) begin
            m_valid = 1'b0;
            m_data  = '0;
            m_ch    = 0;
            m_ptr   = 0;
            m_cnt   = 0;
            chk("rst_valid", valid_out, 0);
            chk("rst_data", data_out, 0);
            chk("rst_ch", ch_out, 0);
            chk("rst_cnt", xfer_cnt_out, 0);
            chk("rst_ready", ready_out, 0);
        end else begin
            chk("m_valid", valid_out, m_valid);
            if (m_valid) begin
                chk("m_data", data_out, m_data);
                chk("m_ch", ch_out, m_ch);
            end
            chk("m_cnt", xfer_cnt_out, m_cnt);
            g     = -1;
            start = mode_in ? 0 : m_ptr;
            for (int k = 0; k < N; k++) begin
                c = (start + k) % N;
                if (g < 0 && valid_in[c]) g = c;
            end
            m_load  = !m_valid || ready_in;
            exp_rdy = (m_load && g >= 0) ? N'(1 << g) : '0;
            chk("m_ready", ready_out, exp_rdy);
            if (m_valid && ready_in) m_cnt = (m_cnt + 1) % (1 << CW);
            if (m_load) begin
                if (g >= 0) begin
                    m_valid = 1'b1;
                    m_data  = data_in[g*W +: W];
                    m_ch    = g;
                    m_ptr   = (g + 1) % N;
                end else begin
                    m_valid = 1'b0;
                end
            end
        end
    end

    task automatic edge1();
        @(posedge clk_in);
        #1;
    endtask

    task automatic do_reset();
        rst_in   = 1'b1;
        valid_in = '0;
        ready_in = 1'b0;
        mode_in  = 1'b0;
        edge1();
        rst_in = 1'b0;
    endtask

    int exp_ch [5] = '{0, 1, 2, 3, 0};

    initial begin
        edge1();
        edge1();

        // Round-robin fairness and counter wrap with CNT_W=4.
        do_reset();
        mode_in  = 1'b0;
        ready_in = 1'b1;
        valid_in = 4'b1111;
        data_in  = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
        for (int k = 0; k < 17; k++) begin
            edge1();
            if (k < 5) begin
                chk("rr_ch", ch_out, exp_ch[k]);
                chk("rr_data", data_out, 8'hA0 + exp_ch[k]);
            end
            chk("rr_cnt", xfer_cnt_out, k % 16);
        end
        chk("cnt_wrap", xfer_cnt_out, 0);

        // Fixed priority with channels 1 and 3 requesting.
        do_reset();
        mode_in  = 1'b1;
        ready_in = 1'b1;
        valid_in = 4'b1010;
        data_in  = {8'h44, 8'h33, 8'h22, 8'h11};
        edge1();
        for (int k = 0; k < 4; k++) begin
            chk("fix_ch", ch_out, 1);
            chk("fix_data", data_out, 8'h22);
            #1;
            chk("fix_ready", ready_out, 4'b0010);
            chk("fix_rdy3", ready_out[3], 0);
            edge1();
        end

        // Backpressure holds channel 2 data.
        do_reset();
        mode_in  = 1'b0;
        ready_in = 1'b0;
        valid_in = 4'b0100;
        data_in  = {8'h33, 8'h5C, 8'h11, 8'h22};
        edge1();
        valid_in = 4'b1111;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("bp_data", data_out, 8'h5C);
            chk("bp_ch", ch_out, 2);
            chk("bp_ready", ready_out, 0);
            edge1();
        end
        ready_in = 1'b1;
        #1;
        chk("bp_release_ready", ready_out, 4'b1000);
        edge1();
        chk("bp_next_ch", ch_out, 3);
        chk("bp_next_data", data_out, 8'h33);

        // Pointer wrap from 3 to channel 0.
        do_reset();
        ready_in = 1'b1;
        valid_in = 4'b0100;
        edge1();
        valid_in = 4'b0011;
        edge1();
        chk("wrap_ch0", ch_out, 0);
        edge1();
        chk("wrap_ch1", ch_out, 1);

        // Reset asserted mid-stream.
        do_reset();
        ready_in = 1'b1;
        valid_in = 4'b1111;
        data_in  = {8'hD3, 8'hD2, 8'hD1, 8'hD0};
        edge1();
        edge1();
        chk("mid_valid_before", valid_out, 1);
        rst_in = 1'b1;
        #1;
        chk("mid_valid_async", valid_out, 0);
        chk("mid_ch_async", ch_out, 0);
        chk("mid_ready_async", ready_out, 0);
        edge1();
        rst_in = 1'b0;
        edge1();
        chk("mid_after_ch", ch_out, 0);
        chk("mid_after_data", data_out, 8'hD0);

        // Mode switch keeps the pointer.
        do_reset();
        ready_in = 1'b1;
        valid_in = 4'b0010;
        edge1();
        mode_in  = 1'b1;
        valid_in = 4'b1100;
        #1;
        chk("ms_fixed_ready", ready_out, 4'b0100);
        edge1();
        chk("ms_fixed_ch", ch_out, 2);
        mode_in = 1'b0;
        #1;
        chk("ms_rr_ready", ready_out, 4'b1000);
        edge1();
        chk("ms_rr_ch", ch_out, 3);

        // Randomized traffic against the model.
        do_reset();
        for (int k = 0; k < 3000; k++) begin
            if ($urandom_range(0, 7) == 0) mode_in = ~mode_in;
            valid_in = N'($urandom);
            data_in  = $urandom;
            ready_in = ($urandom_range(0, 3) != 0);
            rst_in   = ($urandom_range(0, 199) == 0);
            edge1();
        end
        rst_in = 1'b0;
        edge1();
        edge1();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
